// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   F3_*           : funct3 width/sign codes understood by the LSU
//   lsu_state_e    : transaction FSM states
//   lsu_cnt_width  : width of the bus-timeout counter for a given timeout
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_e;

  // Wide enough to hold 0..timeout.
  function automatic int unsigned lsu_cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// Single outstanding request: bus_req/bus_we/bus_addr/bus_be/bus_wdata are held
// stable until the cycle bus_ready is seen; bus_rdata is valid with bus_ready.
interface mem_lsu_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helper for the LSU.
//   Request side : legality check, byte enables and lane-replicated store data
//                  for the access currently offered by EX/MEM.
//   Load side    : lane extraction and sign/zero extension of a returned word,
//                  using the funct3/offset latched when the request was issued.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_rd_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_illegal_o,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    req_illegal_o = 1'b0;
    req_be_o      = 4'b0000;
    req_wdata_o   = req_wdata_i;
    case (req_funct3_i)
      F3_B, F3_BU: begin
        req_be_o    = 4'b0001 << req_off_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        req_be_o      = req_off_i[1] ? 4'b1100 : 4'b0011;
        req_wdata_o   = {2{req_wdata_i[15:0]}};
        req_illegal_o = req_off_i[0];
      end
      F3_W: begin
        req_be_o      = 4'b1111;
        req_illegal_o = |req_off_i;
      end
      default: req_illegal_o = 1'b1;
    endcase
    // Unsigned widths only make sense for loads.
    if (req_we_i && (req_funct3_i == F3_BU || req_funct3_i == F3_HU)) begin
      req_illegal_o = 1'b1;
    end
    if (req_rd_i && req_we_i) begin
      req_illegal_o = 1'b1;
    end
  end

  always_comb begin
    ld_shifted = ld_word_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_data_o = {24'h000000, ld_shifted[7:0]};
      F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_data_o = {16'h0000, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit.
// Takes the EX/MEM access, runs one req/ready transaction on the data bus and
// returns aligned, extended load data towards MEM/WB.
//   clk, rst_n         : clock, asynchronous active-low reset
//   mem_*              : access from EX/MEM (valid, load, store, funct3, addr,
//                        store data, flush)
//   lsu_stall          : freeze upstream pipeline registers
//   lsu_done           : one-cycle completion pulse, with lsu_rdata/flags
//   lsu_misalign/err   : illegal/misaligned access, bus timeout
//   bus                : data-memory bus (master side)
// BUS_TIMEOUT must be at least 1.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_rd,
  input  logic        mem_dram_we,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_flush,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic        lsu_err,
  mem_lsu_if.master   bus
);

  localparam int unsigned CntW = lsu_cnt_width(BUS_TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        kill_q, kill_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;

  logic        start;
  logic        suppress;
  logic        req_illegal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] ld_data;

  assign start = mem_valid & (mem_rd | mem_dram_we) & ~mem_flush;

  lsu_align u_align (
    .req_rd_i      (mem_rd),
    .req_we_i      (mem_dram_we),
    .req_funct3_i  (mem_funct3),
    .req_off_i     (mem_addr[1:0]),
    .req_wdata_i   (mem_wdata),
    .req_illegal_o (req_illegal),
    .req_be_o      (req_be),
    .req_wdata_o   (req_wdata),
    .ld_funct3_i   (ld_f3_q),
    .ld_off_i      (ld_off_q),
    .ld_word_i     (bus.bus_rdata),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    err_d    = 1'b0;
    kill_d   = kill_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    // A flush seen at any point of BUSY hides the result, but never the bus cycle.
    suppress = kill_q | mem_flush;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_illegal) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d  = BUSY;
            req_d    = 1'b1;
            we_d     = mem_dram_we;
            addr_d   = {mem_addr[31:2], 2'b00};
            be_d     = req_be;
            wdata_d  = req_wdata;
            cnt_d    = '0;
            kill_d   = 1'b0;
            ld_f3_d  = mem_funct3;
            ld_off_d = mem_addr[1:0];
          end
        end
      end
      BUSY: begin
        cnt_d  = cnt_q + 1'b1;
        kill_d = suppress;
        if (bus.bus_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!suppress) begin
            done_d = 1'b1;
            if (!we_q) begin
              rdata_d = ld_data;
            end
          end
        end else if (cnt_q == CntW'(BUS_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!suppress) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      DONE: begin
        // The held instruction is still on mem_* here; it must not restart.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      kill_q   <= 1'b0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      kill_q   <= kill_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
    end
  end

  // The IDLE term lets the stall rise in the same cycle the access appears.
  assign lsu_stall = ((state_q == IDLE) & start) | (state_q == BUSY);

  assign lsu_done      = done_q;
  assign lsu_rdata     = rdata_q;
  assign lsu_misalign  = mis_q;
  assign lsu_err       = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: completions are predicted into a queue when an access is
// driven and compared when lsu_done is observed.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_dram_we = 1'b0;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_flush = 1'b0;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        lsu_err;

  mem_lsu_if bus ();

  mem_lsu #(
    .BUS_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_dram_we  (mem_dram_we),
    .mem_funct3   (mem_funct3),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_flush    (mem_flush),
    .lsu_stall    (lsu_stall),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_misalign (lsu_misalign),
    .lsu_err      (lsu_err),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic mis, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.mis   = mis;
    e.err   = err;
    return e;
  endfunction

  // Scoreboard consumer: every completion pulse must have been predicted.
  always @(negedge clk) begin
    if (lsu_done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("done_rdata", lsu_rdata, e.rdata);
        check_eq("done_misalign", 32'(lsu_misalign), 32'(e.mis));
        check_eq("done_err", 32'(lsu_err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Drives one access; waits = bus wait states before bus_ready (large = never).
  task automatic run_access(input string tag, input logic rd, input logic we,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rword,
                            input int waits, input bit flush_mid, input bit exp_done,
                            input exp_t e, input logic [31:0] exp_baddr,
                            input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
                            input int exp_stall, input int exp_req);
    int stall_n = 0;
    int req_n = 0;
    int cyc = 0;
    bit fin = 1'b0;
    @(posedge clk);
    #1;
    if (exp_done) sb.push_back(e);
    mem_valid   = 1'b1;
    mem_rd      = rd;
    mem_dram_we = we;
    mem_funct3  = f3;
    mem_addr    = addr;
    mem_wdata   = wdata;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.bus_ready = 1'b0;
      if (lsu_stall) stall_n++;
      if (bus.bus_req) begin
        req_n++;
        check_eq({tag, "_baddr"}, bus.bus_addr, exp_baddr);
        check_eq({tag, "_be"}, 32'(bus.bus_be), 32'(exp_be));
        check_eq({tag, "_bwe"}, 32'(bus.bus_we), 32'(we));
        check_eq({tag, "_bwdata"}, bus.bus_wdata, exp_bwdata);
        if (flush_mid) mem_flush = 1'b1;
        if (req_n == waits + 1) begin
          bus.bus_ready = 1'b1;
          bus.bus_rdata = rword;
        end
      end else if (!lsu_stall) begin
        fin = 1'b1;
      end
    end
    if (!fin) check_eq({tag, "_finished"}, 32'(fin), 32'd1);
    mem_valid     = 1'b0;
    mem_flush     = 1'b0;
    bus.bus_ready = 1'b0;
    check_eq({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    check_eq({tag, "_req_cycles"}, 32'(req_n), 32'(exp_req));
  endtask

  initial begin
    bus.bus_ready = 1'b0;
    bus.bus_rdata = '0;
    #12;
    check_eq("rst_bus_req", 32'(bus.bus_req), 32'd0);
    check_eq("rst_bus_we", 32'(bus.bus_we), 32'd0);
    check_eq("rst_bus_addr", bus.bus_addr, 32'd0);
    check_eq("rst_bus_be", 32'(bus.bus_be), 32'd0);
    check_eq("rst_bus_wdata", bus.bus_wdata, 32'd0);
    check_eq("rst_rdata", lsu_rdata, 32'd0);
    check_eq("rst_done", 32'(lsu_done), 32'd0);
    check_eq("rst_misalign", 32'(lsu_misalign), 32'd0);
    check_eq("rst_err", 32'(lsu_err), 32'd0);
    check_eq("rst_stall", 32'(lsu_stall), 32'd0);
    rst_n = 1'b1;

    run_access("lw", 1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1,
               mk(32'hDEADBEEF, 0, 0), 32'h100, 4'b1111, 32'h0, 2, 1);
    run_access("lb", 1, 0, F3_B, 32'h103, 32'h0, 32'h80123456, 0, 0, 1,
               mk(32'hFFFFFF80, 0, 0), 32'h100, 4'b1000, 32'h0, 2, 1);
    run_access("lbu", 1, 0, F3_BU, 32'h103, 32'h0, 32'h80123456, 0, 0, 1,
               mk(32'h00000080, 0, 0), 32'h100, 4'b1000, 32'h0, 2, 1);
    // Store leaves the previous load data in place.
    run_access("sh", 0, 1, F3_H, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 1,
               mk(32'h00000080, 0, 0), 32'h200, 4'b1100, 32'hABCDABCD, 5, 4);
    run_access("lw_mis", 1, 0, F3_W, 32'h101, 32'h0, 32'h0, 0, 0, 1,
               mk(32'h0, 1, 0), 32'h0, 4'b0000, 32'h0, 1, 0);
    run_access("lw_tmo", 1, 0, F3_W, 32'h104, 32'h0, 32'h0, 1000, 0, 1,
               mk(32'h0, 0, 1), 32'h104, 4'b1111, 32'h0, 5, 4);
    run_access("lh", 1, 0, F3_H, 32'h106, 32'h0, 32'h80011234, 1, 0, 1,
               mk(32'hFFFF8001, 0, 0), 32'h104, 4'b1100, 32'h0, 3, 2);
    run_access("lhu", 1, 0, F3_HU, 32'h106, 32'h0, 32'h80011234, 1, 0, 1,
               mk(32'h00008001, 0, 0), 32'h104, 4'b1100, 32'h0, 3, 2);
    run_access("sb", 0, 1, F3_B, 32'h001, 32'h000000A5, 32'h0, 0, 0, 1,
               mk(32'h00008001, 0, 0), 32'h0, 4'b0010, 32'hA5A5A5A5, 2, 1);
    run_access("sw", 0, 1, F3_W, 32'h010, 32'h11223344, 32'h0, 0, 0, 1,
               mk(32'h00008001, 0, 0), 32'h10, 4'b1111, 32'h11223344, 2, 1);
    run_access("sbu_ill", 0, 1, F3_BU, 32'h020, 32'h0, 32'h0, 0, 0, 1,
               mk(32'h0, 1, 0), 32'h0, 4'b0000, 32'h0, 1, 0);
    run_access("f3_011", 1, 0, 3'b011, 32'h020, 32'h0, 32'h0, 0, 0, 1,
               mk(32'h0, 1, 0), 32'h0, 4'b0000, 32'h0, 1, 0);
    run_access("rdwe_ill", 1, 1, F3_W, 32'h020, 32'h0, 32'h0, 0, 0, 1,
               mk(32'h0, 1, 0), 32'h0, 4'b0000, 32'h0, 1, 0);
    // Flushed in BUSY: bus cycle completes, no completion pulse, data unchanged.
    run_access("lw_flush", 1, 0, F3_W, 32'h040, 32'h0, 32'h55AA55AA, 1, 1, 0,
               mk(32'h0, 0, 0), 32'h40, 4'b1111, 32'h0, 3, 2);
    check_eq("flush_rdata_hold", lsu_rdata, 32'h0);

    // Flush in IDLE blocks the start entirely.
    @(posedge clk);
    #1;
    mem_valid  = 1'b1;
    mem_rd     = 1'b1;
    mem_funct3 = F3_W;
    mem_addr   = 32'h300;
    mem_flush  = 1'b1;
    @(negedge clk);
    check_eq("idle_flush_stall", 32'(lsu_stall), 32'd0);
    @(negedge clk);
    check_eq("idle_flush_req", 32'(bus.bus_req), 32'd0);
    mem_valid = 1'b0;
    mem_flush = 1'b0;

    // Reset while BUSY.
    @(posedge clk);
    #1;
    mem_valid  = 1'b1;
    mem_rd     = 1'b1;
    mem_funct3 = F3_W;
    mem_addr   = 32'h200;
    @(negedge clk);
    @(negedge clk);
    check_eq("rstbusy_req_before", 32'(bus.bus_req), 32'd1);
    #2;
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    #1;
    check_eq("rstbusy_req", 32'(bus.bus_req), 32'd0);
    check_eq("rstbusy_stall", 32'(lsu_stall), 32'd0);
    bus.bus_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rstbusy_done", 32'(lsu_done), 32'd0);
    bus.bus_ready = 1'b0;
    rst_n = 1'b1;

    run_access("lw_after_rst", 1, 0, F3_W, 32'h010, 32'h0, 32'hCAFEF00D, 2, 0, 1,
               mk(32'hCAFEF00D, 0, 0), 32'h10, 4'b1111, 32'h0, 4, 3);
    @(negedge clk);
    @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
